// File: rtl/contador_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : contador_pc_pkg
// Description : Shared widths, branch type codes and FSM state encoding for
//               the program counter unit.
// Revision    : 1.0 - initial release
// ============================================================================
package contador_pc_pkg;

    localparam int PC_W = 8;

    // Branch type codes as presented on br_type
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    // Fetch unit FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        FLUSH = 2'b10,
        HALT  = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/somador_alvo.sv
`default_nettype none
// ============================================================================
// Module      : somador_alvo
// Description : Branch target adder, target = br_pc + br_offset (mod 256).
// Revision    : 1.0 - initial release
// ============================================================================
module somador_alvo
    import contador_pc_pkg::*;
(
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_offset,
    output logic [PC_W-1:0] target
);

    // The offset is already PC_W bits wide, so sign-extending it to the
    // result width is the identity; a plain modular add yields the target.
    assign target = br_pc + br_offset;

endmodule
`default_nettype wire

// File: rtl/contador_pc.sv
`default_nettype none
// ============================================================================
// Module      : contador_pc
// Description : Program counter / fetch control with branch redirect, one
//               cycle flush, sticky halt and saturating taken-branch count.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_pc
    import contador_pc_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            mem_ready,
    input  logic            br_valid,
    input  logic [1:0]      br_type,
    input  logic            br_zero,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_offset,
    input  logic            halt,
    output logic [PC_W-1:0] pc_out,
    output logic            req_valid,
    output logic            flush,
    output logic            halted,
    output logic [7:0]      taken_count
);

    state_e          state;
    state_e          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] target;
    logic            cond_met;
    logic            taken;

    somador_alvo u_somador_alvo (
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .target    (target)
    );

    // Branch condition decode; only FETCH and FLUSH listen to branches
    always_comb begin
        cond_met = 1'b0;
        case (br_type_e'(br_type))
            BR_BEQ:  cond_met = br_zero;
            BR_BNE:  cond_met = ~br_zero;
            BR_JMP:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
        taken = br_valid && cond_met && ((state == FETCH) || (state == FLUSH));
    end

    // Next-state and next-pc; a taken branch outranks halt and increment
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (taken) begin
            state_next = FLUSH;
            pc_next    = target;
        end else begin
            case (state)
                IDLE:  state_next = FETCH;
                FETCH: begin
                    if (halt) begin
                        state_next = HALT;
                    end else if (mem_ready) begin
                        pc_next = pc + 1'b1;
                    end
                end
                FLUSH: state_next = FETCH;
                HALT:  state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    // State, pc and taken counter registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            taken_count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (taken && (taken_count != 8'hFF)) begin
                taken_count <= taken_count + 8'd1;
            end
        end
    end

    // Outputs are pure decodes of registered state
    always_comb begin
        pc_out    = pc;
        req_valid = (state == FETCH);
        flush     = (state == FLUSH);
        halted    = (state == HALT);
    end

endmodule
`default_nettype wire

// File: tb/tb_contador_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_pc
// Description : Self-checking bench for contador_pc with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_pc;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic       br_valid = 1'b0;
    logic [1:0] br_type = 2'b00;
    logic       br_zero = 1'b0;
    logic [7:0] br_pc = 8'h00;
    logic [7:0] br_offset = 8'h00;
    logic       halt = 1'b0;
    logic [7:0] pc_out;
    logic       req_valid;
    logic       flush;
    logic       halted;
    logic [7:0] taken_count;

    int vectors = 0;
    int errors  = 0;

    // Model: mode 0 waiting after reset, 1 fetching, 2 flushing, 3 halted
    int       m_mode = 0;
    bit [7:0] m_pc   = 8'h00;
    bit [7:0] m_cnt  = 8'h00;

    contador_pc dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_ready   (mem_ready),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .br_zero     (br_zero),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .halt        (halt),
        .pc_out      (pc_out),
        .req_valid   (req_valid),
        .flush       (flush),
        .halted      (halted),
        .taken_count (taken_count)
    );

    always #5 clock = ~clock;

    function automatic logic [18:0] exp_outs();
        return {m_pc, 1'(m_mode == 1), 1'(m_mode == 2), 1'(m_mode == 3), m_cnt};
    endfunction

    task automatic quiet_inputs();
        mem_ready = 1'b0; br_valid = 1'b0; br_type = 2'b00; br_zero = 1'b0;
        br_pc = 8'h00; br_offset = 8'h00; halt = 1'b0;
    endtask

    task automatic set_branch(input logic [1:0] t, input logic z,
                              input logic [7:0] p, input logic [7:0] o);
        br_valid = 1'b1; br_type = t; br_zero = z; br_pc = p; br_offset = o;
    endtask

    // Advance one clock edge and move the model by the architectural rules
    task automatic cycle();
        int       nmode;
        bit [7:0] npc;
        bit [7:0] ncnt;
        int       off;
        bit       tk;
        tk = br_valid && (m_mode == 1 || m_mode == 2) &&
             (br_type == 2'b11 || (br_type == 2'b01 && br_zero) ||
              (br_type == 2'b10 && !br_zero));
        off = int'(br_offset);
        if (off > 127) off = off - 256;
        nmode = m_mode; npc = m_pc; ncnt = m_cnt;
        if (tk) begin
            nmode = 2;
            npc   = 8'((int'(br_pc) + off + 256) % 256);
            if (ncnt != 8'hFF) ncnt = ncnt + 8'd1;
        end else if (m_mode == 0 || m_mode == 2) begin
            nmode = 1;
        end else if (m_mode == 1) begin
            if (halt) nmode = 3;
            else if (mem_ready) npc = 8'((int'(m_pc) + 1) % 256);
        end
        @(posedge clock);
        #1;
        m_mode = nmode; m_pc = npc; m_cnt = ncnt;
    endtask

    // Reset pulse placed mid-cycle, released mid-cycle
    task automatic do_reset();
        quiet_inputs();
        reset_n = 1'b0;
        m_mode = 0; m_pc = 8'h00; m_cnt = 8'h00;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        quiet_inputs();
        mem_ready = 1'b1;
        reset_n = 1'b0;
        #2;
        vectors++;
        if ({pc_out, req_valid, flush, halted, taken_count} !== 19'h0) begin
            errors++;
            $display("FAIL reset_values: got %h required %h",
                     {pc_out, req_valid, flush, halted, taken_count}, 19'h0);
        end
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        m_mode = 0; m_pc = 8'h00; m_cnt = 8'h00;
        #1;
        vectors++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_req_valid: got %b required 0", req_valid);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        mem_ready = 1'b1;
        cycle();  // IDLE -> FETCH
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (pc_out !== 8'(i) || req_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: got pc=%h rv=%b required pc=%h rv=1",
                         i, pc_out, req_valid, 8'(i));
            end
            cycle();
        end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        cycle();
        set_branch(2'b11, 1'b0, 8'hFF, 8'h00);
        cycle();
        quiet_inputs();
        cycle();  // back to FETCH at 0xFF
        vectors++;
        if (pc_out !== 8'hFF || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_setup: got pc=%h rv=%b required pc=ff rv=1", pc_out, req_valid);
        end
        mem_ready = 1'b1;
        cycle();
        vectors++;
        if (pc_out !== 8'h00) begin
            errors++;
            $display("FAIL wrap: got %h required 00", pc_out);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (pc_out !== 8'h00 || req_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h rv=%b required pc=00 rv=1",
                         i, pc_out, req_valid);
            end
        end
    endtask

    task automatic test_branch_beq();
        do_reset();
        cycle();
        mem_ready = 1'b1;
        set_branch(2'b01, 1'b1, 8'h10, 8'hFC);
        cycle();
        quiet_inputs();
        mem_ready = 1'b1;
        vectors++;
        if (pc_out !== 8'h0C || flush !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL beq_taken: got pc=%h fl=%b rv=%b required pc=0c fl=1 rv=0",
                     pc_out, flush, req_valid);
        end
        cycle();
        vectors++;
        if (pc_out !== 8'h0C || flush !== 1'b0 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL beq_refetch: got pc=%h fl=%b rv=%b required pc=0c fl=0 rv=1",
                     pc_out, flush, req_valid);
        end
        set_branch(2'b01, 1'b0, 8'h10, 8'hFC);
        cycle();
        vectors++;
        if (pc_out !== 8'h0D || flush !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_taken: got pc=%h fl=%b required pc=0d fl=0", pc_out, flush);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle();
        set_branch(2'b11, 1'b0, 8'hF0, 8'h20);
        cycle();
        vectors++;
        if (pc_out !== 8'h10 || flush !== 1'b1) begin
            errors++;
            $display("FAIL jump_wrap: got pc=%h fl=%b required pc=10 fl=1", pc_out, flush);
        end
        set_branch(2'b11, 1'b0, 8'h40, 8'h05);
        cycle();
        quiet_inputs();
        vectors++;
        if (pc_out !== 8'h45 || flush !== 1'b1 || taken_count !== 8'd2) begin
            errors++;
            $display("FAIL b2b_jump: got pc=%h fl=%b cnt=%h required pc=45 fl=1 cnt=02",
                     pc_out, flush, taken_count);
        end
        cycle();
        vectors++;
        if (pc_out !== 8'h45 || flush !== 1'b0 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_return: got pc=%h fl=%b rv=%b required pc=45 fl=0 rv=1",
                     pc_out, flush, req_valid);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem_ready = 1'b1;
        cycle();
        cycle();
        cycle();  // pc now 02
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        vectors++;
        if (pc_out !== 8'h02 || halted !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt: got pc=%h h=%b rv=%b required pc=02 h=1 rv=0",
                     pc_out, halted, req_valid);
        end
        set_branch(2'b11, 1'b0, 8'h80, 8'h01);
        cycle();
        cycle();
        vectors++;
        if (pc_out !== 8'h02 || halted !== 1'b1 || flush !== 1'b0 || taken_count !== 8'h00) begin
            errors++;
            $display("FAIL halt_ignores_branch: got pc=%h h=%b fl=%b cnt=%h required pc=02 h=1 fl=0 cnt=00",
                     pc_out, halted, flush, taken_count);
        end
        do_reset();
        cycle();
        halt = 1'b1;
        set_branch(2'b11, 1'b0, 8'h30, 8'h03);
        cycle();
        quiet_inputs();
        vectors++;
        if (pc_out !== 8'h33 || halted !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("FAIL halt_vs_jump: got pc=%h h=%b fl=%b required pc=33 h=0 fl=1",
                     pc_out, halted, flush);
        end
    endtask

    task automatic test_counter_and_reset();
        do_reset();
        cycle();
        for (int i = 0; i < 300; i++) begin
            set_branch(2'b11, 1'b0, 8'(i), 8'h07);
            cycle();
        end
        vectors++;
        if (taken_count !== 8'hFF || flush !== 1'b1) begin
            errors++;
            $display("FAIL count_saturate: got cnt=%h fl=%b required cnt=ff fl=1", taken_count, flush);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({pc_out, req_valid, flush, halted, taken_count} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset_in_flush: got %h required %h",
                     {pc_out, req_valid, flush, halted, taken_count}, 19'h0);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                mem_ready = 1'($urandom_range(0, 3) != 0);
                br_valid  = 1'($urandom_range(0, 2) == 0);
                br_type   = 2'($urandom);
                br_zero   = 1'($urandom);
                br_pc     = 8'($urandom);
                br_offset = 8'($urandom);
                halt      = 1'($urandom_range(0, 29) == 0);
                cycle();
            end
            vectors++;
            if ({pc_out, req_valid, flush, halted, taken_count} !== exp_outs()) begin
                errors++;
                $display("FAIL random[%0d]: got %h required %h", i,
                         {pc_out, req_valid, flush, halted, taken_count}, exp_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap_stall();
        test_branch_beq();
        test_back_to_back();
        test_halt();
        test_counter_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
